key_tone_arbiter: RTL
=====================

// Module: key_tone_arbiter
// PURPOSE
//  Parametrised successor to the combinational key->tone selector. Takes raw piano keys plus
//  octave up/down buttons, synchronises and debounces them, picks a note with last-pressed
//  priority, holds a saturating octave register and drives a registered half-period count
//  for the square-wave tone generator (50 MHz system clock).
// PARAMETERS
//  CLK_HZ          50000000  system clock frequency, Hz
//  NUM_KEYS        7         key count; 1..7 if CHROMATIC=0, 1..12 if CHROMATIC=1
//  CHROMATIC       0         0: keys map C,D,E,F,G,A,B; 1: key i = semitone i above C
//  NUM_OCTAVES     3         octave steps 0..NUM_OCTAVES-1 (1..8)
//  OCT_RESET       1         octave value after reset (< NUM_OCTAVES)
//  DEBOUNCE_CYCLES 500000    consecutive stable cycles to accept a level change (>=2)
//  GLIDE_DIV       5000      cycles per 1-count glide step (GLIDE_EN only, >=1)
//  WIDTH           $clog2(CLK_HZ/131/2)  tone width; KW = max(1,$clog2(NUM_KEYS)); OW = max(1,$clog2(NUM_OCTAVES))
// PORTS
//  clk         in   1         system clock
//  rst         in   1         synchronous, active-high reset
//  keys        in   NUM_KEYS  raw asynchronous key levels, 1 = pressed
//  oct_up      in   1         raw octave-up button, 1 = pressed
//  oct_dn      in   1         raw octave-down button, 1 = pressed
//  tone        out  WIDTH     half-period count minus 1 for the tone generator
//  tone_valid  out  1         gate: 1 while a note sounds
//  note_on     out  1         one-cycle pulse when a new note/octave starts sounding
//  active_key  out  KW        index of sounding key (held value when tone_valid=0)
//  octave      out  OW        current octave
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst). Reset: tone=0,
//    tone_valid=0, note_on=0, active_key=0, octave=OCT_RESET, all sync/debounce/stack state 0.
//  - Every raw input: 2-flop synchroniser, then debouncer: counter increments while synced
//    level != debounced level, clears when equal; debounced level flips when counter reaches
//    DEBOUNCE_CYCLES-1 (i.e. after DEBOUNCE_CYCLES differing cycles). Glitches shorter are dropped.
//  - Octave: rising edge of debounced oct_up -> +1, oct_dn -> -1, saturating at 0 and
//    NUM_OCTAVES-1; both edges in the same cycle -> no change.
//  - Arbitration FSM IDLE/PLAY. IDLE: on any debounced press -> PLAY with that key; several in
//    one cycle -> highest index. PLAY: new press -> switch to it (last-pressed wins); release of
//    active key with others held -> highest-index held key; none held -> IDLE. Release of a
//    non-active key: no change.
//  - Tone: BASE[k] = CLK_HZ/(2*f_k), f = 131,139,147,156,165,175,185,196,208,220,233,247 Hz
//    (C3..B3, integer division); target = (BASE[k] >> octave) - 1, truncated to WIDTH.
//  - Outputs registered: tone/tone_valid/active_key update on the edge after the debounced
//    event; octave change while PLAY retargets tone same latency.
//  - note_on: 1 cycle, coincident with first tone_valid cycle of a new key or octave
//    (IDLE->PLAY, key switch, octave change in PLAY). Never asserted in IDLE.
//  - IDLE: tone holds last value, tone_valid=0. Reset mid-note: outputs to reset values next edge.
// CONFIGURATION
//  GLIDE_EN defined: on key switch or octave change within PLAY, tone steps by 1 toward target
//   every GLIDE_DIV cycles until equal; note_on still pulses at switch; IDLE->PLAY jumps
//   directly to target; reset clears glide counter.
//  GLIDE_EN undefined: tone jumps to target in the single registered cycle; no glide logic.
// TESTING (CLK_HZ=50e6, DEBOUNCE_CYCLES=4, defaults otherwise, GLIDE_EN off unless noted)
//  - Reset, set octave to 0 (one oct_dn), hold keys[0] -> tone=190838, tone_valid=1,
//    note_on one pulse, active_key=0; 3-cycle key glitch before that -> no change.
//  - Hold key 0 then press key 5 -> tone=113635, active_key=5, note_on pulse; release 5 ->
//    back to key 0 tone=190838; release 0 -> tone_valid=0, tone held, no note_on.
//  - Key 5 held, octave 0->1->2 via oct_up -> tone 56817 then 28408, note_on each; extra
//    oct_up at 2 -> octave stays 2, no note_on; oct_up+oct_dn together -> no change.
//  - Press keys 2 and 4 in same cycle from IDLE -> active_key=4; assert rst mid-note ->
//    tone=0, tone_valid=0, octave=1 next edge.
//  - GLIDE_EN, GLIDE_DIV=1: key 0 -> key 5 at octave 0 -> tone decrements by 1/cycle from
//    190838 to 113635 then holds; tone_valid stays 1.

Source files
------------

// File: rtl/key_tone_arbiter.sv
// Debounced piano-key arbiter: last-pressed priority, saturating octave, registered tone count.
// Optional macro GLIDE_EN: tone slews by one count every GLIDE_DIV cycles on key/octave change.
module key_tone_arbiter #(
  parameter int CLK_HZ          = 50000000,
  parameter int NUM_KEYS        = 7,
  parameter int CHROMATIC       = 0,
  parameter int NUM_OCTAVES     = 3,
  parameter int OCT_RESET       = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int GLIDE_DIV       = 5000,
  parameter int WIDTH           = $clog2(CLK_HZ / 131 / 2),
  parameter int KW              = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  parameter int OW              = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                oct_up,
  input  logic                oct_dn,
  output logic [WIDTH-1:0]    tone,
  output logic                tone_valid,
  output logic                note_on,
  output logic [KW-1:0]       active_key,
  output logic [OW-1:0]       octave
);

  localparam int NIN = NUM_KEYS + 2;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (GLIDE_DIV < 1 || DEBOUNCE_CYCLES < 2 || OCT_RESET >= NUM_OCTAVES ||
      NUM_KEYS < 1 || NUM_KEYS > (CHROMATIC != 0 ? 12 : 7)) begin : g_bad_cfg
    $error("key_tone_arbiter: illegal parameter combination");
  end

  typedef enum logic {IDLE, PLAY} state_t;

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [CW-1:0]  cnt_q [NIN];

  state_t              state_q, state_d;
  logic [KW-1:0]       key_q, key_d;
  logic [OW-1:0]       oct_q, oct_d;
  logic [WIDTH-1:0]    tone_q, tone_d, tgt;
  logic                note_on_q, note_on_d;
  logic [NUM_KEYS-1:0] held, press;
  logic                up_rise, dn_rise, act_rel;

  // Highest set index; used both for simultaneous presses and fallback after release.
  function automatic logic [KW-1:0] top_idx(input logic [NUM_KEYS-1:0] v);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (v[i]) r = KW'(i);
    return r;
  endfunction

  function automatic int base_of(input logic [KW-1:0] k);
    int s;
    if (CHROMATIC != 0) s = int'(k);
    else begin
      case (k)
        KW'(0):  s = 0;
        KW'(1):  s = 2;
        KW'(2):  s = 4;
        KW'(3):  s = 5;
        KW'(4):  s = 7;
        KW'(5):  s = 9;
        default: s = 11;
      endcase
    end
    case (s)
      0:       return CLK_HZ / (2 * 131);
      1:       return CLK_HZ / (2 * 139);
      2:       return CLK_HZ / (2 * 147);
      3:       return CLK_HZ / (2 * 156);
      4:       return CLK_HZ / (2 * 165);
      5:       return CLK_HZ / (2 * 175);
      6:       return CLK_HZ / (2 * 185);
      7:       return CLK_HZ / (2 * 196);
      8:       return CLK_HZ / (2 * 208);
      9:       return CLK_HZ / (2 * 220);
      10:      return CLK_HZ / (2 * 233);
      default: return CLK_HZ / (2 * 247);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] target_of(input logic [KW-1:0] k, input logic [OW-1:0] o);
    int b;
    b = (base_of(k) >> o) - 1;
    return WIDTH'(b);
  endfunction

  assign raw = {oct_dn, oct_up, keys};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NIN; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          cnt_q[i] <= '0;
          deb_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign held    = deb_q[NUM_KEYS-1:0];
  assign press   = held & ~deb_prev_q[NUM_KEYS-1:0];
  assign act_rel = deb_prev_q[key_q] & ~held[key_q];
  assign up_rise = deb_q[NUM_KEYS] & ~deb_prev_q[NUM_KEYS];
  assign dn_rise = deb_q[NUM_KEYS+1] & ~deb_prev_q[NUM_KEYS+1];

  always_comb begin
    oct_d = oct_q;
    if (up_rise && !dn_rise && oct_q != OW'(NUM_OCTAVES - 1))
      oct_d = oct_q + OW'(1);
    else if (dn_rise && !up_rise && oct_q != '0)
      oct_d = oct_q - OW'(1);
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    note_on_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|press) begin
          state_d   = PLAY;
          key_d     = top_idx(press);
          note_on_d = 1'b1;
        end
      end
      default: begin
        if (|press) begin
          key_d     = top_idx(press);
          note_on_d = 1'b1;
        end else if (act_rel) begin
          if (|held) begin
            key_d     = top_idx(held);
            note_on_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        if (state_d == PLAY && oct_d != oct_q) note_on_d = 1'b1;
      end
    endcase
  end

  assign tgt = target_of(key_d, oct_d);

`ifdef GLIDE_EN
  localparam int GW = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;
  localparam logic [GW-1:0] GCMAX = GW'(GLIDE_DIV - 1);
  logic [GW-1:0] gcnt_q, gcnt_d;

  // Slew only while staying in PLAY; entering PLAY from IDLE lands on the target at once.
  always_comb begin
    tone_d = tone_q;
    gcnt_d = '0;
    if (state_d == PLAY) begin
      if (state_q == IDLE) begin
        tone_d = tgt;
      end else if (tone_q != tgt) begin
        if (gcnt_q == GCMAX) tone_d = (tone_q < tgt) ? tone_q + WIDTH'(1) : tone_q - WIDTH'(1);
        else gcnt_d = gcnt_q + GW'(1);
      end
    end
  end
`else
  always_comb begin
    tone_d = tone_q;
    if (state_d == PLAY) tone_d = tgt;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      oct_q     <= OW'(OCT_RESET);
      tone_q    <= '0;
      note_on_q <= 1'b0;
`ifdef GLIDE_EN
      gcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      oct_q     <= oct_d;
      tone_q    <= tone_d;
      note_on_q <= note_on_d;
`ifdef GLIDE_EN
      gcnt_q    <= gcnt_d;
`endif
    end
  end

  assign tone       = tone_q;
  assign tone_valid = (state_q == PLAY);
  assign note_on    = note_on_q;
  assign active_key = key_q;
  assign octave     = oct_q;

endmodule
